// File: rtl/ssd1306_pkg.sv
// Shared types and constants for the SSD1306-style SPI transmit path.
package ssd1306_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StShift,
    StWait,
    StHold,
    StGap
  } tx_state_e;

  localparam int unsigned DEFAULT_CLK_DIV = 2;
  localparam int unsigned DEFAULT_CS_GAP  = 4;

  localparam logic [7:0] CMD_INVERT_OFF = 8'hA6;
  localparam logic [7:0] CMD_INVERT_ON  = 8'hA7;
  localparam logic [7:0] CMD_PAGE_BASE  = 8'hB0;

  // Page-select command byte for page 0..7
  function automatic logic [7:0] page_cmd(input logic [2:0] page);
    return CMD_PAGE_BASE | {5'b00000, page};
  endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// Half-period divider: one-cycle tick every DIV cycles, restartable so the
// first tick after a restart lands exactly DIV cycles later.
module spi_tick_gen #(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam logic [7:0] Reload = 8'(DIV - 1);

  logic [7:0] cnt_q, cnt_d;

  // Count down to zero, then reload; a restart forces a fresh full period
  always_comb begin
    cnt_d = cnt_q - 8'd1;
    if (restart || cnt_q == 8'd0) begin
      cnt_d = Reload;
    end
  end

  assign tick = (cnt_q == 8'd0) && !restart;

  // Divider state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= Reload;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ssd1306_spi_tx.sv
// Host-side SPI byte transmitter for the SSD1306-style display link.
// Bytes arrive on a valid/ready stream and leave MSB-first; wclk idles low
// and din only changes on falling edges (or on accept, while wclk is low).
module ssd1306_spi_tx
  import ssd1306_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV,
  parameter int unsigned CS_GAP  = DEFAULT_CS_GAP
) (
  input  logic       CLK25MHz,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_dc,
  input  logic       tx_last,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       cs,
  output logic       wclk,
  output logic       din,
  output logic       write_en,
  output logic       busy
);

  localparam logic [7:0] GapReload = 8'(CS_GAP - 1);

  tx_state_e  state_q, state_d;
  logic [7:0] shreg_q, shreg_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] gap_cnt_q, gap_cnt_d;
  logic       last_q, last_d;
  logic       cs_q, cs_d;
  logic       wclk_q, wclk_d;
  logic       din_q, din_d;
  logic       we_q, we_d;
  logic       busy_q, busy_d;
  logic       ready_q, ready_d;

  logic accept;
  logic tick;

  assign accept = tx_valid && ready_q;

  spi_tick_gen #(
    .DIV(CLK_DIV)
  ) u_tick (
    .clk    (CLK25MHz),
    .rst_n  (reset_n),
    .restart(accept),
    .tick   (tick)
  );

  // State and output registers; reset drops everything back to the idle levels
  always_ff @(posedge CLK25MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      shreg_q   <= 8'h00;
      bit_cnt_q <= 3'd0;
      gap_cnt_q <= 8'h00;
      last_q    <= 1'b0;
      cs_q      <= 1'b1;
      wclk_q    <= 1'b0;
      din_q     <= 1'b0;
      we_q      <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      last_q    <= last_d;
      cs_q      <= cs_d;
      wclk_q    <= wclk_d;
      din_q     <= din_d;
      we_q      <= we_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
    end
  end

  // Next-state: byte completes on the eighth falling edge
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StWait: if (accept) state_d = StSetup;
      StSetup:        if (tick) state_d = StShift;
      StShift: begin
        if (tick && wclk_q && bit_cnt_q == 3'd7) begin
          state_d = last_q ? StHold : StWait;
        end
      end
      StHold:         if (tick) state_d = StGap;
      StGap:          if (gap_cnt_q == 8'd0) state_d = StIdle;
      default:        state_d = StIdle;
    endcase
  end

  // Next values of the registered outputs and datapath
  always_comb begin
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    last_d    = last_q;
    wclk_d    = wclk_q;
    din_d     = din_q;
    we_d      = we_q;

    if (accept) begin
      shreg_d   = tx_data;
      last_d    = tx_last;
      din_d     = tx_data[7];
      we_d      = tx_dc;
      bit_cnt_d = 3'd0;
    end

    unique case (state_q)
      StSetup: if (tick) wclk_d = 1'b1;
      StShift: begin
        if (tick) begin
          if (wclk_q) begin
            wclk_d    = 1'b0;
            // Wraps 7->0 on the completing edge; din keeps bit 0 after that
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q != 3'd7) begin
              din_d   = shreg_q[6];
              shreg_d = {shreg_q[6:0], 1'b0};
            end
          end else begin
            wclk_d = 1'b1;
          end
        end
      end
      StHold: if (tick) gap_cnt_d = GapReload;
      StGap:  if (gap_cnt_q != 8'd0) gap_cnt_d = gap_cnt_q - 8'd1;
      default: ;
    endcase

    cs_d    = (state_d == StIdle) || (state_d == StGap);
    ready_d = (state_d == StIdle) || (state_d == StWait);
    busy_d  = (state_d != StIdle);
  end

  assign tx_ready = ready_q;
  assign cs       = cs_q;
  assign wclk     = wclk_q;
  assign din      = din_q;
  assign write_en = we_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_ssd1306_spi_tx.sv
// Directed bench for ssd1306_spi_tx: default instance with a receiver model,
// plus a CLK_DIV=1 / CS_GAP=1 instance for the fast corner.
module tb_ssd1306_spi_tx;
  import ssd1306_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] tx_data;
  logic       tx_dc, tx_last, tx_valid, v2;
  logic       tx_ready, cs, wclk, din, write_en, busy;
  logic       ready2, cs2, wclk2, din2, we2, busy2;

  int checks = 0;
  int failures = 0;

  always #20 clk = ~clk;

  ssd1306_spi_tx u_dut (
    .CLK25MHz(clk),
    .reset_n (reset_n),
    .tx_data (tx_data),
    .tx_dc   (tx_dc),
    .tx_last (tx_last),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .cs      (cs),
    .wclk    (wclk),
    .din     (din),
    .write_en(write_en),
    .busy    (busy)
  );

  ssd1306_spi_tx #(
    .CLK_DIV(1),
    .CS_GAP (1)
  ) u_fast (
    .CLK25MHz(clk),
    .reset_n (reset_n),
    .tx_data (tx_data),
    .tx_dc   (tx_dc),
    .tx_last (tx_last),
    .tx_valid(v2),
    .tx_ready(ready2),
    .cs      (cs2),
    .wclk    (wclk2),
    .din     (din2),
    .write_en(we2),
    .busy    (busy2)
  );

  // Edge-indexed timestamps: cyc at a negedge is the index of the last posedge
  int unsigned cyc = 0;
  int unsigned acc_t = 0, acc2_t = 0, acc_cnt = 0;
  int unsigned cs_rise_t = 0, busy_fall_t = 0, cs_rise_cnt = 0;
  int unsigned cs2_rise_t = 0, busy2_fall_t = 0;
  int unsigned rise_tq[$];
  int unsigned rise2_tq[$];
  logic wclk_p = 1'b0, cs_p = 1'b1, busy_p = 1'b0;
  logic wclk2_p = 1'b0, cs2_p = 1'b1, busy2_p = 1'b0;
  logic din_mid = 1'b0, din2_mid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (tx_valid && tx_ready) begin
      acc_cnt <= acc_cnt + 1;
      acc_t   <= cyc + 1;
    end
    if (v2 && ready2) acc2_t <= cyc + 1;
  end

  always @(negedge clk) begin
    wclk_p   <= wclk;
    cs_p     <= cs;
    busy_p   <= busy;
    wclk2_p  <= wclk2;
    cs2_p    <= cs2;
    busy2_p  <= busy2;
    din_mid  <= din;
    din2_mid <= din2;
    if (wclk && !wclk_p) rise_tq.push_back(cyc);
    if (cs && !cs_p) begin
      cs_rise_t   <= cyc;
      cs_rise_cnt <= cs_rise_cnt + 1;
    end
    if (!busy && busy_p) busy_fall_t <= cyc;
    if (wclk2 && !wclk2_p) rise2_tq.push_back(cyc);
    if (cs2 && !cs2_p) cs2_rise_t <= cyc;
    if (!busy2 && busy2_p) busy2_fall_t <= cyc;
  end

  // Receiver model for the default instance: samples din on wclk rises while
  // cs is low, decodes invert / page commands and collects data bytes
  logic [7:0]  rx_sr = 8'h00;
  logic [7:0]  rx_last_byte = 8'h00;
  logic [7:0]  rx_data_q[$];
  logic        rx_invert = 1'b0;
  logic        rx_we0 = 1'b0;
  int          rx_n = 0;
  int unsigned page_addr = 0, fb_addr = 0;
  int          rise_cnt = 0, unstable = 0, we_glitch = 0;
  wire  [7:0]  rx_byte = {rx_sr[6:0], din};

  always @(posedge wclk or posedge cs) begin
    if (cs) begin
      rx_n <= 0;
    end else begin
      rise_cnt <= rise_cnt + 1;
      if (din !== din_mid) unstable <= unstable + 1;
      rx_sr <= rx_byte;
      if (rx_n == 0) rx_we0 <= write_en;
      else if (write_en !== rx_we0) we_glitch <= we_glitch + 1;
      if (rx_n == 7) begin
        rx_n         <= 0;
        rx_last_byte <= rx_byte;
        if (write_en) begin
          rx_data_q.push_back(rx_byte);
          fb_addr <= fb_addr + 1;
        end else if (rx_byte == CMD_INVERT_ON) begin
          rx_invert <= 1'b1;
        end else if (rx_byte == CMD_INVERT_OFF) begin
          rx_invert <= 1'b0;
        end else if ((rx_byte & 8'hF8) == CMD_PAGE_BASE) begin
          page_addr <= {19'd0, rx_byte[2:0], 10'd0};
          fb_addr   <= {19'd0, rx_byte[2:0], 10'd0};
        end
      end else begin
        rx_n <= rx_n + 1;
      end
    end
  end

  // Minimal capture for the fast instance
  logic [7:0] sr2 = 8'h00;
  int         rise2_cnt = 0, unstable2 = 0;
  always @(posedge wclk2) begin
    if (!cs2) begin
      sr2       <= {sr2[6:0], din2};
      rise2_cnt <= rise2_cnt + 1;
      if (din2 !== din2_mid) unstable2 <= unstable2 + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    checks++;
    failures++;
    $error("FAIL %s observed=timeout expected=event", tag);
  endtask

  // Offer a byte and hold tx_valid until the accept edge; returns on the next negedge
  task automatic offer(input logic [7:0] d, input logic dc, input logic last);
    int n = 0;
    tx_data = d; tx_dc = dc; tx_last = last; tx_valid = 1'b1;
    forever begin
      @(posedge clk);
      if (tx_ready) break;
      n++;
      if (n > 300) begin timeout("offer"); break; end
    end
    @(negedge clk);
  endtask

  task automatic offer2(input logic [7:0] d, input logic dc, input logic last);
    int n = 0;
    tx_data = d; tx_dc = dc; tx_last = last; v2 = 1'b1;
    forever begin
      @(posedge clk);
      if (ready2) break;
      n++;
      if (n > 300) begin timeout("offer2"); break; end
    end
    @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk);
    while (busy) begin
      @(negedge clk);
      n++;
      if (n > 400) begin timeout(tag); break; end
    end
    @(negedge clk);
  endtask

  task automatic wait_idle2(input string tag);
    int n = 0;
    @(negedge clk);
    while (busy2) begin
      @(negedge clk);
      n++;
      if (n > 400) begin timeout(tag); break; end
    end
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned a1, a2, a3, a4, n0;
    int r0, r1, d0, n, bad;
    reset_n = 1'b1; tx_data = 8'h00; tx_dc = 1'b0; tx_last = 1'b0;
    tx_valid = 1'b0; v2 = 1'b0;
    #5 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {26'd0, cs, wclk, din, write_en, busy, tx_ready}, 32'b100000);
    chk("reset_outputs_fast", {26'd0, cs2, wclk2, din2, we2, busy2, ready2}, 32'b100000);
    reset_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {31'd0, tx_ready}, 32'd1);

    // Single command 0xA7, last byte of its frame
    r0 = rise_cnt;
    rise_tq.delete();
    offer(CMD_INVERT_ON, 1'b0, 1'b1);
    tx_valid = 1'b0;
    wait_idle("single_idle");
    chk("single_byte", {24'd0, rx_last_byte}, 32'hA7);
    chk("single_rises", rise_cnt - r0, 32'd8);
    chk("single_first_rise", rise_tq[0] - acc_t, 32'd2);
    chk("single_last_rise", rise_tq[7] - acc_t, 32'd30);
    chk("single_cs_low", cs_rise_t - acc_t, 32'd34);
    chk("single_busy_tail", busy_fall_t - cs_rise_t, 32'd4);
    chk("single_we", {31'd0, write_en}, 32'd0);
    chk("single_invert", {31'd0, rx_invert}, 32'd1);

    // Frame: page 3 then three data bytes, tx_valid held high throughout
    n0 = cs_rise_cnt;
    d0 = rx_data_q.size();
    offer(page_cmd(3'd3), 1'b0, 1'b0); a1 = acc_t;
    offer(8'h01, 1'b1, 1'b0);          a2 = acc_t;
    offer(8'h00, 1'b1, 1'b0);          a3 = acc_t;
    offer(8'h01, 1'b1, 1'b1);          a4 = acc_t;
    tx_valid = 1'b0;
    wait_idle("frame_idle");
    chk("frame_spacing_1", a2 - a1, 32'd33);
    chk("frame_spacing_2", a3 - a2, 32'd33);
    chk("frame_spacing_3", a4 - a3, 32'd33);
    chk("frame_cs_rises", cs_rise_cnt - n0, 32'd1);
    chk("frame_page_addr", page_addr, 32'd3072);
    chk("frame_data_count", rx_data_q.size() - d0, 32'd3);
    chk("frame_data", {8'd0, rx_data_q[d0], rx_data_q[d0+1], rx_data_q[d0+2]}, 32'h010001);
    chk("frame_we", {31'd0, write_en}, 32'd1);

    // Stall in WAIT for 50 cycles
    r0 = rise_cnt;
    offer(page_cmd(3'd1), 1'b0, 1'b0);
    tx_valid = 1'b0;
    n = 0;
    while (!tx_ready) begin
      @(negedge clk);
      n++;
      if (n > 100) begin timeout("stall_wait"); break; end
    end
    r1 = rise_cnt;
    chk("stall_rises_before", r1 - r0, 32'd8);
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if ({cs, wclk, tx_ready} !== 3'b001) bad++;
    end
    chk("stall_lines", bad, 32'd0);
    chk("stall_no_edges", rise_cnt - r1, 32'd0);
    offer(CMD_INVERT_OFF, 1'b0, 1'b1);
    tx_valid = 1'b0;
    wait_idle("stall_idle");
    chk("stall_close_byte", {24'd0, rx_last_byte}, 32'hA6);
    chk("stall_page_addr", page_addr, 32'd1024);
    chk("stall_invert", {31'd0, rx_invert}, 32'd0);

    // Handshake: valid held through SHIFT/HOLD/GAP of a closing byte
    n0 = acc_cnt;
    offer(CMD_INVERT_OFF, 1'b0, 1'b1); a1 = acc_t;
    offer(CMD_INVERT_ON, 1'b0, 1'b1);  a2 = acc_t;
    tx_valid = 1'b0;
    wait_idle("hs_idle");
    chk("hs_accept_spacing", a2 - a1, 32'd39);
    chk("hs_accept_count", acc_cnt - n0, 32'd2);
    chk("hs_invert", {31'd0, rx_invert}, 32'd1);

    // Reset after the third rising edge of a data byte
    r0 = rise_cnt;
    d0 = rx_data_q.size();
    offer(8'hFF, 1'b1, 1'b1);
    tx_valid = 1'b0;
    n = 0;
    while (rise_cnt - r0 < 3) begin
      @(negedge clk);
      n++;
      if (n > 100) begin timeout("rst_wait"); break; end
    end
    chk("rst_pre_lines", {29'd0, cs, din, write_en}, 32'b011);
    #5 reset_n = 1'b0;
    #1;
    chk("rst_mid_outputs", {26'd0, cs, wclk, din, write_en, busy, tx_ready}, 32'b100000);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    offer(CMD_INVERT_OFF, 1'b0, 1'b1);
    tx_valid = 1'b0;
    wait_idle("rst_idle");
    chk("rst_fresh_byte", {24'd0, rx_last_byte}, 32'hA6);
    chk("rst_invert", {31'd0, rx_invert}, 32'd0);
    chk("rst_no_partial", rx_data_q.size() - d0, 32'd0);

    chk("din_stable", unstable, 32'd0);
    chk("we_steady", we_glitch, 32'd0);

    // Fast instance: CLK_DIV=1, CS_GAP=1
    r0 = rise2_cnt;
    rise2_tq.delete();
    offer2(8'h5A, 1'b1, 1'b1);
    v2 = 1'b0;
    wait_idle2("fast_idle");
    chk("fast_byte", {24'd0, sr2}, 32'h5A);
    chk("fast_rises", rise2_cnt - r0, 32'd8);
    chk("fast_first_rise", rise2_tq[0] - acc2_t, 32'd1);
    chk("fast_last_rise", rise2_tq[7] - acc2_t, 32'd15);
    chk("fast_cs_low", cs2_rise_t - acc2_t, 32'd17);
    chk("fast_gap", busy2_fall_t - cs2_rise_t, 32'd1);
    chk("fast_din_stable", unstable2, 32'd0);
    chk("fast_we", {31'd0, we2}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
